// File: rtl/day_5_query.sv
// day_5_query: query-side reader of the day 5 ID range table.
// Ranges are loaded over a valid/ready stream into a small table. Each ID is
// then compared against one table entry per cycle. Every ID produces a hit
// verdict, and the number of hits is reported once the last ID is done.
module day_5_query #(
   parameter int NUM_RANGE = 182,
   parameter int WIDTH     = 50,
   parameter int IDX_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             range_valid,
   output logic             range_ready,
   input  logic [WIDTH-1:0] range_start,
   input  logic [WIDTH-1:0] range_end,
   input  logic             range_last,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [WIDTH-1:0] id,
   input  logic             id_last,
   output logic             hit_valid,
   output logic             hit,
   output logic             overflow,
   output logic             finished,
   output logic [WIDTH-1:0] result
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_WAIT_ID = 3'd2;
   localparam logic [2:0] S_SCAN    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [IDX_W-1:0] NUM_RANGE_C = IDX_W'(NUM_RANGE);

   logic [WIDTH-1:0] tbl_start_r [NUM_RANGE];
   logic [WIDTH-1:0] tbl_end_r   [NUM_RANGE];

   logic [2:0]       state_r;
   logic [2:0]       state_nxt_s;
   logic [IDX_W-1:0] count_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] id_r;
   logic             id_last_r;
   logic [WIDTH-1:0] fresh_r;
   logic             range_hs_s;
   logic             id_hs_s;
   logic             table_full_s;
   logic             match_s;
   logic             verdict_s;
   logic             hit_s;

   assign range_hs_s   = range_valid && range_ready;
   assign id_hs_s      = id_valid && id_ready;
   assign table_full_s = (count_r >= NUM_RANGE_C);

   // Compare the current table entry with the latched ID and decide if the scan ends this cycle.
   always_comb begin
      match_s   = 1'b0;
      verdict_s = 1'b0;
      hit_s     = 1'b0;
      if (state_r == S_SCAN) begin
         if (count_r == {IDX_W{1'b0}}) begin
            // An empty table means an immediate miss.
            verdict_s = 1'b1;
            hit_s     = 1'b0;
         end else begin
            // A reversed range (start > end) cannot satisfy both bounds, so it never matches.
            match_s   = (tbl_start_r[idx_r] <= id_r) && (id_r <= tbl_end_r[idx_r]);
            verdict_s = match_s || (idx_r == (count_r - IDX_W'(1)));
            hit_s     = match_s;
         end
      end else begin
         match_s   = 1'b0;
         verdict_s = 1'b0;
         hit_s     = 1'b0;
      end
   end

   // Next-state selection for the load / wait / scan sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) state_nxt_s = S_LOAD;
            else       state_nxt_s = state_r;
         end
         S_LOAD: begin
            if (range_hs_s && range_last) state_nxt_s = S_WAIT_ID;
            else                          state_nxt_s = S_LOAD;
         end
         S_WAIT_ID: begin
            if (id_hs_s) state_nxt_s = S_SCAN;
            else         state_nxt_s = S_WAIT_ID;
         end
         S_SCAN: begin
            if (verdict_s) state_nxt_s = id_last_r ? S_DONE : S_WAIT_ID;
            else           state_nxt_s = S_SCAN;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Table storage; contents are only meaningful below count_r, so they are not reset.
   always_ff @(posedge clk) begin
      if ((state_r == S_LOAD) && range_hs_s && !table_full_s) begin
         tbl_start_r[count_r] <= range_start;
         tbl_end_r[count_r]   <= range_end;
      end
   end

   // Control state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         count_r     <= {IDX_W{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         id_r        <= {WIDTH{1'b0}};
         id_last_r   <= 1'b0;
         fresh_r     <= {WIDTH{1'b0}};
         range_ready <= 1'b0;
         id_ready    <= 1'b0;
         hit_valid   <= 1'b0;
         hit         <= 1'b0;
         overflow    <= 1'b0;
         finished    <= 1'b0;
         result      <= {WIDTH{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         range_ready <= (state_nxt_s == S_LOAD);
         id_ready    <= (state_nxt_s == S_WAIT_ID);
         hit_valid   <= 1'b0;
         hit         <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  count_r  <= {IDX_W{1'b0}};
                  fresh_r  <= {WIDTH{1'b0}};
                  overflow <= 1'b0;
                  finished <= 1'b0;
                  result   <= {WIDTH{1'b0}};
               end
            end
            S_LOAD: begin
               if (range_hs_s) begin
                  if (!table_full_s) count_r  <= count_r + IDX_W'(1);
                  else               overflow <= 1'b1;
               end
            end
            S_WAIT_ID: begin
               if (id_hs_s) begin
                  id_r      <= id;
                  id_last_r <= id_last;
                  idx_r     <= {IDX_W{1'b0}};
               end
            end
            S_SCAN: begin
               if (verdict_s) begin
                  hit_valid <= 1'b1;
                  hit       <= hit_s;
                  fresh_r   <= fresh_r + WIDTH'(hit_s);
                  if (id_last_r) begin
                     finished <= 1'b1;
                     result   <= fresh_r + WIDTH'(hit_s);
                  end
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            default: begin
               count_r <= {IDX_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_day_5_query.sv
// Directed self-checking bench for day_5_query (table depth reduced to 4).
module tb_day_5_query;

   localparam int W = 50;

   logic         clk = 1'b0;
   logic         rst, start;
   logic         range_valid, range_ready, range_last;
   logic [W-1:0] range_start, range_end;
   logic         id_valid, id_ready, id_last;
   logic [W-1:0] id;
   logic         hit_valid, hit, overflow, finished;
   logic [W-1:0] result;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   day_5_query #(.NUM_RANGE(4), .WIDTH(W), .IDX_W(3)) dut (
      .clk(clk), .rst(rst), .start(start),
      .range_valid(range_valid), .range_ready(range_ready),
      .range_start(range_start), .range_end(range_end), .range_last(range_last),
      .id_valid(id_valid), .id_ready(id_ready), .id(id), .id_last(id_last),
      .hit_valid(hit_valid), .hit(hit), .overflow(overflow),
      .finished(finished), .result(result)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_range(input logic [W-1:0] s, input logic [W-1:0] e, input logic last);
      int n;
      n = 0;
      range_start = s; range_end = e; range_last = last; range_valid = 1'b1;
      while (!range_ready && n < 50) begin tick(); n++; end
      tick();
      range_valid = 1'b0; range_last = 1'b0;
   endtask

   // Offers one ID, waits for its verdict; lat counts edges after acceptance.
   task automatic send_id(input logic [W-1:0] v, input logic last,
                          output logic h, output int lat, output logic leak);
      int n;
      n = 0;
      id = v; id_last = last; id_valid = 1'b1;
      while (!id_ready && n < 50) begin tick(); n++; end
      tick();
      id_valid = 1'b0; id_last = 1'b0;
      lat = 0; leak = 1'b0;
      while (!hit_valid && lat < 50) begin
         tick();
         lat++;
         if (!hit_valid && id_ready) leak = 1'b1;
      end
      h = hit_valid ? hit : 1'bx;
   endtask

   task automatic load_a();
      send_range(50'd3,  50'd5,  1'b0);
      send_range(50'd10, 50'd14, 1'b0);
      send_range(50'd16, 50'd20, 1'b0);
      send_range(50'd12, 50'd18, 1'b1);
   endtask

   task automatic run_a();
      logic [W-1:0] ids  [6];
      logic         exph [6];
      int           expl [6];
      logic h, leak;
      int   lat;
      ids  = '{50'd1, 50'd5, 50'd8, 50'd11, 50'd17, 50'd32};
      exph = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      expl = '{4, 1, 4, 2, 3, 4};
      pulse_start();
      chk("a_range_ready", {63'd0, range_ready}, 64'd1);
      load_a();
      for (int i = 0; i < 6; i++) begin
         send_id(ids[i], (i == 5), h, lat, leak);
         chk($sformatf("a_hit%0d", i), {63'd0, h}, {63'd0, exph[i]});
         chk($sformatf("a_lat%0d", i), 64'(lat), 64'(expl[i]));
      end
      tick();
      chk("a_finished", {63'd0, finished}, 64'd1);
      chk("a_result", 64'(result), 64'd3);
      chk("a_overflow_full", {63'd0, overflow}, 64'd0);
      chk("a_done_ready", {62'd0, range_ready, id_ready}, 64'd0);
   endtask

   initial begin
      logic h, leak;
      int   lat, n;
      rst = 1'b1; start = 1'b0;
      range_valid = 1'b0; range_start = '0; range_end = '0; range_last = 1'b0;
      id_valid = 1'b0; id = '0; id_last = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_flags", {58'd0, range_ready, id_ready, hit_valid, hit, overflow, finished}, 64'd0);
      chk("reset_result", 64'(result), 64'd0);

      // Main scenario
      run_a();

      // Boundary: inclusive ends of a single range
      pulse_start();
      chk("b_cleared", {62'd0, finished, overflow}, 64'd0);
      send_range(50'd10, 50'd14, 1'b1);
      send_id(50'd9,  1'b0, h, lat, leak); chk("b_hit9",  {63'd0, h}, 64'd0);
      send_id(50'd10, 1'b0, h, lat, leak); chk("b_hit10", {63'd0, h}, 64'd1);
      send_id(50'd14, 1'b0, h, lat, leak); chk("b_hit14", {63'd0, h}, 64'd1);
      send_id(50'd15, 1'b1, h, lat, leak); chk("b_hit15", {63'd0, h}, 64'd0);
      tick();
      chk("b_result", 64'(result), 64'd2);

      // Latency
      pulse_start();
      send_range(50'd0, 50'd0, 1'b0);
      send_range(50'd7, 50'd7, 1'b0);
      send_range(50'd9, 50'd9, 1'b1);
      send_id(50'd9, 1'b0, h, lat, leak);
      chk("c_hit9", {63'd0, h}, 64'd1);
      chk("c_lat9", 64'(lat), 64'd3);
      chk("c_ready_low9", {63'd0, leak}, 64'd0);
      send_id(50'd8, 1'b1, h, lat, leak);
      chk("c_hit8", {63'd0, h}, 64'd0);
      chk("c_lat8", 64'(lat), 64'd3);
      chk("c_ready_low8", {63'd0, leak}, 64'd0);

      // Overflow: fifth range (the only one holding 100) is dropped
      pulse_start();
      send_range(50'd0,  50'd1,   1'b0);
      send_range(50'd2,  50'd3,   1'b0);
      send_range(50'd4,  50'd5,   1'b0);
      send_range(50'd6,  50'd7,   1'b0);
      send_range(50'd90, 50'd110, 1'b0);
      send_range(50'd8,  50'd9,   1'b1);
      chk("d_overflow", {63'd0, overflow}, 64'd1);
      send_id(50'd100, 1'b1, h, lat, leak);
      chk("d_hit100", {63'd0, h}, 64'd0);
      chk("d_lat100", 64'(lat), 64'd4);
      tick();
      chk("d_result", 64'(result), 64'd0);
      chk("d_overflow_sticky", {63'd0, overflow}, 64'd1);

      // Degenerate reversed range and idle WAIT_ID
      pulse_start();
      chk("e_overflow_clr", {63'd0, overflow}, 64'd0);
      send_range(50'd20, 50'd10, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      chk("e_wait_ready", {62'd0, range_ready, id_ready}, 64'd1);
      chk("e_wait_quiet", {62'd0, hit_valid, finished}, 64'd0);
      send_id(50'd15, 1'b1, h, lat, leak);
      chk("e_hit15", {63'd0, h}, 64'd0);
      tick();
      chk("e_result", 64'(result), 64'd0);
      chk("e_finished", {63'd0, finished}, 64'd1);

      // Reset in the middle of a scan
      pulse_start();
      load_a();
      id = 50'd1; id_last = 1'b0; id_valid = 1'b1;
      n = 0;
      while (!id_ready && n < 50) begin tick(); n++; end
      tick();
      id_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("f_rst_flags", {58'd0, range_ready, id_ready, hit_valid, hit, overflow, finished}, 64'd0);
      chk("f_rst_result", 64'(result), 64'd0);
      tick();
      chk("f_idle_quiet", {61'd0, range_ready, id_ready, hit_valid}, 64'd0);
      run_a();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
